// File: rtl/dmem_portb_arbiter.sv
// dmem_portb_arbiter
// ------------------
// Shares the wide DMEM port B between NUM_CH bus masters (ch0 = CCD writer,
// ch1 = accelerator, further channels for future DMA). Grants are given in
// round-robin order as bursts of up to MAX_BURST beats. Writes are suppressed
// while the CPU is halted. Read data is routed back to the issuing channel
// through a tag pipeline that matches the RAM read latency.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   [NUM_CH]         per-channel beat request
//   wr         in   [NUM_CH]         per-channel 1 = write beat, 0 = read beat
//   last       in   [NUM_CH]         per-channel final beat of a burst
//   addr       in   [NUM_CH*ADDR_W]  per-channel address, ch i at [i*ADDR_W +: ADDR_W]
//   wdata      in   [NUM_CH*DATA_W]  per-channel write data, packed like addr
//   halt       in   CPU halt, suppresses RAM writes
//   gnt        out  [NUM_CH]  beat accept, one-hot or zero
//   rvalid     out  [NUM_CH]  read data valid, one-hot or zero
//   rdata      out  [DATA_W]  read data broadcast to all channels
//   ram_addr   out  RAM address_b
//   ram_data   out  RAM data_b
//   ram_rden   out  RAM rden_b
//   ram_wren   out  RAM wren_b
//   ram_q      in   RAM q_b
//   wr_dropped out  sticky: a write beat was accepted while halt was high
module dmem_portb_arbiter #(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 256,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          req,
   input  logic [NUM_CH-1:0]          wr,
   input  logic [NUM_CH-1:0]          last,
   input  logic [NUM_CH*ADDR_W-1:0]   addr,
   input  logic [NUM_CH*DATA_W-1:0]   wdata,
   input  logic                       halt,
   output logic [NUM_CH-1:0]          gnt,
   output logic [NUM_CH-1:0]          rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic [ADDR_W-1:0]          ram_addr,
   output logic [DATA_W-1:0]          ram_data,
   output logic                       ram_rden,
   output logic                       ram_wren,
   input  logic [DATA_W-1:0]          ram_q,
   output logic                       wr_dropped
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t              state;
   logic [CH_W-1:0]     ptr;
   logic [CH_W-1:0]     own;
   logic [CNT_W-1:0]    cnt;
   logic                wr_dropped_q;

   logic [RD_LAT-1:0]   pipe_vld;
   logic [CH_W-1:0]     pipe_tag [RD_LAT];

   logic                req_own;
   logic                wr_own;
   logic                last_own;
   logic                beat;
   logic                cnt_at_max;
   logic [CH_W-1:0]     own_next;
   logic [CH_W-1:0]     pick;
   logic                pick_found;
   logic                out_vld;

   // Owner-side views of the request bundle and the beat qualifier.
   // rst gates beat so that every output is quiet during a reset cycle.
   assign req_own    = req[own];
   assign wr_own     = wr[own];
   assign last_own   = last[own];
   assign beat       = (state == S_BUSY) && req_own && !rst;
   assign cnt_at_max = (cnt == CNT_W'(MAX_BURST - 1));
   assign own_next   = (own == CH_W'(NUM_CH - 1)) ? '0 : own + 1'b1;

   // Round-robin search: first requester at ptr, ptr+1, ... modulo NUM_CH.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         pick       = (!pick_found && req[(int'(ptr) + k) % NUM_CH])
                      ? CH_W'((int'(ptr) + k) % NUM_CH) : pick;
         pick_found = pick_found | req[(int'(ptr) + k) % NUM_CH];
      end
   end

   // Grant and RAM port drive; everything is zero outside a beat.
   always_comb begin
      gnt      = '0;
      ram_addr = '0;
      ram_data = '0;
      ram_rden = 1'b0;
      ram_wren = 1'b0;
      if (beat) begin
         gnt[own] = 1'b1;
         ram_addr = addr[int'(own)*ADDR_W +: ADDR_W];
         ram_data = wdata[int'(own)*DATA_W +: DATA_W];
         ram_rden = !wr_own;
         ram_wren = wr_own && !halt;
      end else begin
         gnt      = '0;
      end
   end

   // Arbitration state machine: owner selection, burst counting, release.
   // A single release path covers last and burst-limit together, so ptr
   // advances only once even when both hold in the same beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         ptr          <= '0;
         own          <= '0;
         cnt          <= '0;
         wr_dropped_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  state <= S_BUSY;
                  own   <= pick;
                  cnt   <= '0;
               end
            end
            S_BUSY: begin
               if (!req_own || (beat && (last_own || cnt_at_max))) begin
                  state <= S_IDLE;
                  ptr   <= own_next;
               end else if (beat) begin
                  cnt   <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
         if (beat && wr_own && halt) begin
            wr_dropped_q <= 1'b1;
         end
      end
   end

   // Read-return tag pipeline, one stage per RAM latency cycle.
   // Reset empties it, so reads in flight at reset never return.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_tag[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= beat && !wr_own;
         pipe_tag[0] <= own;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   assign out_vld = pipe_vld[RD_LAT-1] && !rst;

   // Decode the exiting tag into the per-channel read-valid strobe.
   always_comb begin
      rvalid = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rvalid[i] = out_vld && (pipe_tag[RD_LAT-1] == CH_W'(i));
      end
   end

   assign rdata      = rst ? '0 : ram_q;
   assign wr_dropped = wr_dropped_q && !rst;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Self-checking bench for dmem_portb_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a transaction-level
// reference model (owner/burst bookkeeping in plain integers, a word-array
// memory image and a queue of pending read returns).
module tb_dmem_portb_arbiter;

   localparam int NCH = 3;
   localparam int AW  = 7;
   localparam int DW  = 256;
   localparam int LAT = 2;
   localparam int MB  = 8;

   logic              clk;
   logic              rst;
   logic [NCH-1:0]    req, wr, last;
   logic [NCH*AW-1:0] addr;
   logic [NCH*DW-1:0] wdata;
   logic              halt;
   logic [NCH-1:0]    gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_data;
   logic              ram_rden, ram_wren;
   logic [DW-1:0]     ram_q;
   logic              wr_dropped;

   dmem_portb_arbiter #(
      .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .last(last), .addr(addr),
      .wdata(wdata), .halt(halt), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_rden(ram_rden),
      .ram_wren(ram_wren), .ram_q(ram_q), .wr_dropped(wr_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM on port B with LAT cycles of read latency.
   logic [DW-1:0] mem [128] = '{default: '0};
   logic [DW-1:0] qpipe [LAT] = '{default: '0};
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      qpipe[0] <= mem[ram_addr];
      for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
   end
   assign ram_q = qpipe[LAT-1];

   // ---------------- reference model ----------------
   typedef struct { int due; int tag; logic [DW-1:0] data; } rd_t;
   rd_t           pend[$];
   bit            m_busy;
   int            m_own, m_beats, m_ptr;
   bit            m_drop;
   logic [DW-1:0] m_mem [128];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [AW-1:0] a_ch [NCH];
   logic [DW-1:0] d_ch [NCH];
   logic [NCH-1:0] obs_gnt, obs_rvalid;
   logic [DW-1:0]  obs_rdata;
   logic           obs_wren, obs_drop;

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle against the
   // model, then advance the model across the rising edge.
   task automatic step(input bit r, input logic [NCH-1:0] rq, input logic [NCH-1:0] wv,
                       input logic [NCH-1:0] lv, input bit h);
      logic [NCH-1:0] e_gnt, e_rv;
      logic [AW-1:0]  e_addr;
      logic [DW-1:0]  e_data, e_rd;
      logic           e_rden, e_wren;
      bit             is_beat, chk_rd;
      rd_t            e;
      rst = r; req = rq; wr = wv; last = lv; halt = h;
      for (int i = 0; i < NCH; i++) begin
         addr[i*AW +: AW]  = a_ch[i];
         wdata[i*DW +: DW] = d_ch[i];
      end
      #4;
      e_gnt = '0; e_rv = '0; e_addr = '0; e_data = '0; e_rd = '0;
      e_rden = 1'b0; e_wren = 1'b0; chk_rd = r;
      is_beat = !r && m_busy && rq[m_own];
      if (is_beat) begin
         e_gnt[m_own] = 1'b1;
         e_addr = a_ch[m_own];
         e_data = d_ch[m_own];
         e_rden = !wv[m_own];
         e_wren = wv[m_own] && !h;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
         e = pend.pop_front();
         if (!r) begin
            e_rv[e.tag] = 1'b1;
            e_rd = e.data;
            chk_rd = 1;
         end
      end
      obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata;
      obs_wren = ram_wren; obs_drop = wr_dropped;
      chk("gnt", 512'(gnt), 512'(e_gnt));
      chk("ram_port", 512'({ram_addr, ram_data, ram_rden, ram_wren}),
          512'({e_addr, e_data, e_rden, e_wren}));
      chk("rvalid", 512'(rvalid), 512'(e_rv));
      chk("wr_dropped", 512'(wr_dropped), 512'(!r && m_drop));
      if (chk_rd) chk("rdata", 512'(rdata), 512'(e_rd));
      // model update across the edge
      if (r) begin
         m_busy = 0; m_own = 0; m_beats = 0; m_ptr = 0; m_drop = 0;
         pend.delete();
      end else if (!m_busy) begin
         if (rq != '0) begin
            for (int k = NCH-1; k >= 0; k--)
               if (rq[(m_ptr + k) % NCH]) m_own = (m_ptr + k) % NCH;
            m_busy = 1; m_beats = 0;
         end
      end else if (!rq[m_own]) begin
         m_busy = 0; m_ptr = (m_own + 1) % NCH;
      end else begin
         if (wv[m_own]) begin
            if (h) m_drop = 1;
            else   m_mem[a_ch[m_own]] = d_ch[m_own];
         end else begin
            pend.push_back('{due: cyc + LAT, tag: m_own, data: m_mem[a_ch[m_own]]});
         end
         m_beats++;
         if (lv[m_own] || m_beats == MB) begin
            m_busy = 0; m_ptr = (m_own + 1) % NCH;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      logic [DW-1:0] pat_a5;
      logic [NCH-1:0] rq_r;
      int wc;
      for (int i = 0; i < 128; i++) m_mem[i] = '0;
      for (int i = 0; i < NCH; i++) begin a_ch[i] = '0; d_ch[i] = '0; end
      m_busy = 0; m_own = 0; m_beats = 0; m_ptr = 0; m_drop = 0;
      rst = 1'b1; req = '0; wr = '0; last = '0; halt = 1'b0; addr = '0; wdata = '0;
      @(posedge clk);
      #1;

      // reset state
      step(1, 3'b000, 3'b000, 3'b000, 0);
      step(1, 3'b000, 3'b000, 3'b000, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);

      // single requester: ch0 writes 0x10..0x13, last on beat 4
      a_ch[0] = 7'h10; d_ch[0] = rnd_word();
      step(0, 3'b001, 3'b001, 3'b000, 0);
      wc = 0;
      for (int b = 0; b < 4; b++) begin
         a_ch[0] = 7'(7'h10 + b); d_ch[0] = rnd_word();
         step(0, 3'b001, 3'b001, (b == 3) ? 3'b001 : 3'b000, 0);
         if (obs_wren) wc++;
      end
      chk("single_wren_count", 512'(wc), 512'(4));
      step(0, 3'b000, 3'b000, 3'b000, 0);
      // ptr now points at ch1: simultaneous ch0/ch1 request goes to ch1
      step(0, 3'b011, 3'b000, 3'b011, 0);
      step(0, 3'b011, 3'b000, 3'b011, 0);
      chk("rr_after_release", 512'(obs_gnt), 512'(3'b010));

      // contention without last: bursts of MB with one-cycle bubbles
      for (int c = 0; c < 3*MB + 4; c++) begin
         a_ch[0] = 7'($urandom_range(0, 15)); a_ch[1] = 7'($urandom_range(0, 15));
         d_ch[0] = rnd_word(); d_ch[1] = rnd_word();
         step(0, 3'b011, 3'b011, 3'b000, 0);
      end
      step(0, 3'b000, 3'b000, 3'b000, 0);

      // read latency: preload 0x05 with A5.. via ch1 then read it back
      for (int i = 0; i < DW/8; i++) pat_a5[i*8 +: 8] = 8'hA5;
      a_ch[1] = 7'h05; d_ch[1] = pat_a5;
      step(0, 3'b010, 3'b010, 3'b010, 0);
      step(0, 3'b010, 3'b010, 3'b010, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);
      d_ch[1] = rnd_word();
      step(0, 3'b010, 3'b000, 3'b010, 0);
      step(0, 3'b010, 3'b000, 3'b010, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);
      chk("rd_lat_rvalid", 512'(obs_rvalid), 512'(3'b010));
      chk("rd_lat_rdata", 512'(obs_rdata), 512'(pat_a5));

      // read return across release: ch0 single read, ch1 granted next
      a_ch[0] = 7'h05; a_ch[1] = 7'h30; d_ch[1] = rnd_word();
      step(0, 3'b011, 3'b010, 3'b001, 0);
      step(0, 3'b011, 3'b010, 3'b001, 0);
      step(0, 3'b010, 3'b010, 3'b000, 0);
      step(0, 3'b010, 3'b010, 3'b000, 0);
      chk("xrel_gnt", 512'(obs_gnt), 512'(3'b010));
      chk("xrel_rvalid", 512'(obs_rvalid), 512'(3'b001));
      step(0, 3'b000, 3'b000, 3'b000, 0);

      // halt: ch0 write to 0x20 dropped, then read 0x20 back
      a_ch[0] = 7'h20; d_ch[0] = rnd_word();
      step(0, 3'b001, 3'b001, 3'b001, 1);
      step(0, 3'b001, 3'b001, 3'b001, 1);
      step(0, 3'b000, 3'b000, 3'b000, 0);
      chk("halt_sticky", 512'(obs_drop), 512'(1'b1));
      step(0, 3'b001, 3'b000, 3'b001, 0);
      step(0, 3'b001, 3'b000, 3'b001, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);

      // reset at beat 3 of a 6-beat ch2 read burst
      step(0, 3'b100, 3'b000, 3'b000, 0);
      for (int b = 0; b < 2; b++) begin
         a_ch[2] = 7'(7'h40 + b);
         step(0, 3'b100, 3'b000, 3'b000, 0);
      end
      step(1, 3'b100, 3'b000, 3'b000, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);
      step(0, 3'b000, 3'b000, 3'b000, 0);
      step(0, 3'b110, 3'b000, 3'b110, 0);
      step(0, 3'b110, 3'b000, 3'b110, 0);
      chk("ptr_after_reset", 512'(obs_gnt), 512'(3'b010));

      // randomized traffic
      rq_r = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 3) == 0) rq_r[i] = ~rq_r[i];
            a_ch[i] = 7'($urandom_range(0, 15));
            d_ch[i] = rnd_word();
         end
         step($urandom_range(0, 199) == 0, rq_r, NCH'($urandom),
              {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0)},
              $urandom_range(0, 7) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_portb_arbiter.md
# dmem_portb_arbiter

Parametrised arbiter for the wide DMEM port B. It lets NUM_CH bus masters (CCD writer, accelerator, future DMA) share one RAM port, replacing today's direct single-owner hookup of that port. It provides round-robin burst grants, halt-gated writes, and tagged read-return routing with configurable RAM read latency. It sits between the masters and the `ram` instance, alongside the CPU, which keeps port A.

## Interface
Parameters:
- NUM_CH, 2: number of requesters (ch0 = CCD, ch1 = accelerator); legal range 2..8
- ADDR_W, 7: port-B word address width
- DATA_W, 256: port-B data width
- RD_LAT, 1: RAM cycles from rden to valid q_b; legal range 1..4
- MAX_BURST, 8: maximum beats per grant; a power of 2, 1..64

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CH  per-channel beat request
- wr  in  NUM_CH  per-channel: 1 = write beat, 0 = read beat
- last  in  NUM_CH  per-channel: marks the final beat of a burst
- addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CH*DATA_W  per-channel write data, packed the same way as addr
- halt  in  1  CPU halt; suppresses RAM writes
- gnt  out  NUM_CH  per-channel beat accept, one-hot or zero
- rvalid  out  NUM_CH  per-channel read data valid, one-hot or zero
- rdata  out  DATA_W  read data, broadcast to all channels
- ram_addr  out  ADDR_W  to RAM address_b
- ram_data  out  DATA_W  to RAM data_b
- ram_rden  out  1  to RAM rden_b
- ram_wren  out  1  to RAM wren_b
- ram_q  in  DATA_W  from RAM q_b
- wr_dropped  out  1  sticky flag: a write beat was accepted while halt was high

## Operation
- State machine, two states:
  - IDLE: no owner, gnt = 0.
  - BUSY: has owner `own`, beat counter `cnt`.
- Round-robin pointer `ptr` holds the highest-priority channel.
- IDLE -> BUSY:
  - Triggered when any req bit is high.
  - own = first requesting channel searching ptr, ptr+1, … mod NUM_CH.
  - cnt = 0.
- In BUSY, gnt[own] = req[own]; all other gnt bits are 0. A beat is the cycle where req[own] & gnt[own] are both high.
- On each beat:
  - ram_addr and ram_data take channel own's addr and wdata.
  - Write beat (wr[own] = 1): ram_wren = ~halt.
  - Read beat (wr[own] = 0): ram_rden = 1.
  - cnt increments.
- Release, BUSY -> IDLE:
  - Triggered by (a) a beat with last[own] = 1, (b) a beat with cnt = MAX_BURST-1, or (c) req[own] low in a BUSY cycle.
  - On release, ptr = (own+1) mod NUM_CH.
- Read return:
  - A pipeline of RD_LAT stages, each holding {valid, channel tag}, is loaded on every read beat.
  - rvalid[tag] asserts when the entry exits the pipeline; rdata = ram_q.
  - Reads in flight are still returned after release or an owner change.
- wr_dropped sets on a write beat with halt = 1 and clears only on rst.
- No RAM operation happens outside a beat: ram_rden = ram_wren = 0, ram_addr = 0, ram_data = 0.
- Width rules:
  - cnt is clog2(MAX_BURST)+1 bits.
  - ptr and own are clog2(NUM_CH) bits.
  - Wrap from NUM_CH-1 to 0 applies for non-power-of-2 NUM_CH.

## Timing
- Reset values: state IDLE, ptr = 0, own = 0, cnt = 0, read pipe empty, wr_dropped = 0.
- While rst is high, all outputs are 0. A reset mid-burst discards in-flight reads; their rvalid never asserts.
- Arbitration latency: req rising in IDLE at cycle N gives gnt at cycle N+1, then one beat per cycle while req is held.
- Every release costs one IDLE bubble cycle; back-to-back bursts from different channels are separated by exactly one cycle with gnt = 0.
- Read beat at cycle N produces rvalid and rdata at cycle N+RD_LAT.
- gnt and the ram_* outputs are combinational from registered state plus req/wr/addr/wdata; there is no register stage on the request path.
- MAX_BURST = 1: every beat releases, giving strict alternation among requesters.
- last and MAX_BURST reached in the same beat: a single release, no double ptr advance.
- halt toggling mid-burst affects only the write beats in cycles where halt is high.

## Test plan
- Single requester: ch0 writes 4 beats to addr 0x10..0x13 with last on beat 4. Expect gnt at cycles 1..4, ram_wren on 4 cycles, IDLE at cycle 5, ptr = 1.
- Contention: ch0 and ch1 request continuously with last never set, MAX_BURST = 8. Expect grants of ch0×8, bubble, ch1×8, bubble, ch0×8.
- Read latency: RD_LAT = 2, ch1 reads addr 0x05 preloaded with 0xA5…A5. Expect rvalid[1] and rdata = 0xA5…A5 exactly 2 cycles after the beat.
- Reads across release: ch0 reads with last, then ch1 is granted immediately. Expect ch0's rvalid to arrive during ch1's grant, with the correct tag.
- Halt: halt = 1 during a ch0 write beat to 0x20. Expect ram_wren = 0, the RAM word unchanged, wr_dropped = 1 held until rst.
- Reset mid-burst: rst at beat 3 of a 6-beat read burst. Expect all outputs 0 the next cycle, no rvalid for beats 1..3, ptr = 0.
